// File: rtl/gyro_axis_sequencer.sv
// Gyro axis sequencer: once per sample frame, requests a roll sample and then
// a pitch sample from a shared gyro source, and publishes both to the servo
// outputs together.
//
// Optional feature: define GYRO_SEQ_TIMEOUT_EN to abort a request that is not
// acknowledged within TIMEOUT cycles; without it the sequencer waits forever
// and timeout_err is tied low.
//
// Ports:
//   clk           clock, rising edge
//   reset         asynchronous, active-high reset
//   enable        permits new frames to start
//   gyro_req      sample request to the gyro source
//   gyro_axis     axis being requested (0 = roll, 1 = pitch)
//   gyro_ack      source acknowledge, gyro_data valid in the same cycle
//   gyro_data     signed 16-bit sample
//   servo_roll    last published roll command
//   servo_pitch   last published pitch command
//   update_valid  one-cycle pulse when both servo outputs update
//   busy          high while a frame is in progress
//   overrun       one-cycle pulse when a tick is dropped because busy
//   timeout_err   one-cycle pulse when a request is aborted
module gyro_axis_sequencer #(
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned TIMEOUT  = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        gyro_req,
  output logic        gyro_axis,
  input  logic        gyro_ack,
  input  logic [15:0] gyro_data,
  output logic [15:0] servo_roll,
  output logic [15:0] servo_pitch,
  output logic        update_valid,
  output logic        busy,
  output logic        overrun,
  output logic        timeout_err
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  // An out-of-range configuration never produces a tick, so no frame starts.
  localparam bit CFG_OK = (TICK_DIV >= 2) && (TICK_DIV <= 65535) &&
                          (TIMEOUT >= 1) && (TIMEOUT <= 255);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ_ROLL  = 2'd1,
    REQ_PITCH = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] tick_cnt;
  logic [15:0] roll_shadow;
  logic        tick_c;

  assign tick_c = CFG_OK && (tick_cnt == TICK_LAST);

  // Free-running frame divider, independent of enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= 16'd0;
    end else if (tick_c) begin
      tick_cnt <= 16'd0;
    end else begin
      tick_cnt <= tick_cnt + 16'd1;
    end
  end

`ifdef GYRO_SEQ_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  // Frame sequencer; every output is registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      roll_shadow  <= 16'd0;
      servo_roll   <= 16'd0;
      servo_pitch  <= 16'd0;
      gyro_req     <= 1'b0;
      gyro_axis    <= 1'b0;
      update_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
`ifdef GYRO_SEQ_TIMEOUT_EN
      timeout_err  <= 1'b0;
      wait_cnt     <= 8'd0;
`endif
    end else begin
      update_valid <= 1'b0;
      overrun      <= tick_c && (state != IDLE);
`ifdef GYRO_SEQ_TIMEOUT_EN
      timeout_err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (tick_c && enable) begin
            state     <= REQ_ROLL;
            gyro_req  <= 1'b1;
            gyro_axis <= 1'b0;
            busy      <= 1'b1;
`ifdef GYRO_SEQ_TIMEOUT_EN
            wait_cnt  <= 8'd0;
`endif
          end
        end
        REQ_ROLL: begin
          if (gyro_ack) begin
            roll_shadow <= gyro_data;
            state       <= REQ_PITCH;
            gyro_axis   <= 1'b1;
`ifdef GYRO_SEQ_TIMEOUT_EN
            wait_cnt    <= 8'd0;
          end else if (wait_cnt == WAIT_LAST) begin
            state       <= IDLE;
            gyro_req    <= 1'b0;
            gyro_axis   <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt    <= wait_cnt + 8'd1;
`endif
          end
        end
        REQ_PITCH: begin
          // Both servo outputs load at the same edge: no partial update.
          if (gyro_ack) begin
            servo_roll   <= roll_shadow;
            servo_pitch  <= gyro_data;
            update_valid <= 1'b1;
            state        <= IDLE;
            gyro_req     <= 1'b0;
            gyro_axis    <= 1'b0;
            busy         <= 1'b0;
`ifdef GYRO_SEQ_TIMEOUT_EN
          end else if (wait_cnt == WAIT_LAST) begin
            state       <= IDLE;
            gyro_req    <= 1'b0;
            gyro_axis   <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt    <= wait_cnt + 8'd1;
`endif
          end
        end
        default: begin
          state     <= IDLE;
          gyro_req  <= 1'b0;
          gyro_axis <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gyro_axis_sequencer.sv
// Self-checking bench for gyro_axis_sequencer. Expected servo pairs are queued
// when the pitch acknowledge is driven and compared when update_valid fires.
module tb_gyro_axis_sequencer;

  localparam int unsigned TICK_DIV = 10;
  localparam int unsigned TIMEOUT  = 20;
`ifdef GYRO_SEQ_TIMEOUT_EN
  localparam int EXP_TMO = 1;
`else
  localparam int EXP_TMO = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        gyro_ack = 1'b0;
  logic [15:0] gyro_data = 16'd0;
  logic        gyro_req, gyro_axis, update_valid, busy, overrun, timeout_err;
  logic [15:0] servo_roll, servo_pitch;

  gyro_axis_sequencer #(.TICK_DIV(TICK_DIV), .TIMEOUT(TIMEOUT)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .gyro_req     (gyro_req),
    .gyro_axis    (gyro_axis),
    .gyro_ack     (gyro_ack),
    .gyro_data    (gyro_data),
    .servo_roll   (servo_roll),
    .servo_pitch  (servo_pitch),
    .update_valid (update_valid),
    .busy         (busy),
    .overrun      (overrun),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard and output monitor, sampled 2 time units after the rising edge.
  logic [31:0] sb_q[$];
  logic [31:0] prev_servo = 32'd0;
  int upd_cnt = 0;
  int ovr_cnt = 0;
  int tmo_cnt = 0;

  always @(posedge clk) begin
    logic [31:0] exp_pair;
    #2;
    if (reset) begin
      prev_servo = 32'd0;
    end else begin
      if (update_valid) begin
        upd_cnt++;
        if (sb_q.size() == 0) begin
          check("unexpected_update", 32'd1, 32'd0);
        end else begin
          exp_pair = sb_q.pop_front();
          check("servo_roll", 32'(servo_roll), 32'(exp_pair[31:16]));
          check("servo_pitch", 32'(servo_pitch), 32'(exp_pair[15:0]));
        end
      end else if ({servo_roll, servo_pitch} != prev_servo) begin
        check("servo_hold", {servo_roll, servo_pitch}, prev_servo);
      end
      prev_servo = {servo_roll, servo_pitch};
      if (overrun) ovr_cnt++;
      if (timeout_err) tmo_cnt++;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    gyro_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_servo_roll", 32'(servo_roll), 32'd0);
    check("rst_servo_pitch", 32'(servo_pitch), 32'd0);
    check("rst_outputs", {26'd0, gyro_req, gyro_axis, update_valid, busy, overrun, timeout_err}, 32'd0);
    reset = 1'b0;
  endtask

  // Bounded wait (at negedges) for gyro_req; returns cycles waited.
  task automatic wait_req(input string tag, output int waited);
    waited = 0;
    while (!gyro_req && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (!gyro_req) check({tag, "_req_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic drive_ack(input logic [15:0] d, input int delay);
    repeat (delay) @(negedge clk);
    gyro_ack = 1'b1;
    gyro_data = d;
    @(negedge clk);
    gyro_ack = 1'b0;
    gyro_data = 16'($urandom);
  endtask

  task automatic run_frame(input logic [15:0] r, input logic [15:0] p,
                           input int roll_wait, input int pitch_wait);
    int w;
    wait_req("frame", w);
    check("axis_roll", 32'(gyro_axis), 32'd0);
    drive_ack(r, roll_wait);
    check("req_pitch", {30'd0, gyro_req, gyro_axis}, 32'd3);
    sb_q.push_back({r, p});
    drive_ack(p, pitch_wait);
    check("frame_end", {29'd0, update_valid, gyro_req, busy}, 32'd4);
    @(negedge clk);
    check("upd_single", 32'(update_valid), 32'd0);
  endtask

  initial begin
    int n, u0, o0, reqs;

    // Enable low: no frames ever start.
    do_reset();
    reqs = 0;
    repeat (50) begin
      @(negedge clk);
      if (gyro_req) reqs++;
    end
    check("en0_no_req", 32'(reqs), 32'd0);
    check("en0_servo", {servo_roll, servo_pitch}, 32'd0);
    check("en0_no_upd", 32'(upd_cnt), 32'd0);

    // First request appears TICK_DIV cycles after reset release.
    enable = 1'b1;
    do_reset();
    wait_req("first", n);
    check("first_tick_lat", 32'(n), 32'(TICK_DIV));
    run_frame(16'h1234, 16'hFEDC, 2, 2);
    run_frame(16'h8000, 16'h7FFF, 0, 0);
    run_frame(16'hFFFF, 16'h0001, 1, 3);

    // Roll ack withheld across one tick: exactly one overrun, frame completes.
    o0 = ovr_cnt;
    run_frame(16'h0100, 16'h0200, 12, 2);
    check("overrun_cnt", 32'(ovr_cnt - o0), 32'd1);
    enable = 1'b0;

    // Acknowledge held in IDLE is ignored.
    u0 = upd_cnt;
    reqs = 0;
    gyro_ack = 1'b1;
    gyro_data = 16'h5555;
    repeat (20) begin
      @(negedge clk);
      if (gyro_req) reqs++;
    end
    gyro_ack = 1'b0;
    check("idle_ack_no_req", 32'(reqs), 32'd0);
    check("idle_ack_no_upd", 32'(upd_cnt - u0), 32'd0);
    check("idle_ack_servo", {servo_roll, servo_pitch}, 32'h0100_0200);

`ifdef GYRO_SEQ_TIMEOUT_EN
    // Unacknowledged roll request aborts after TIMEOUT cycles.
    enable = 1'b1;
    wait_req("tmo", n);
    enable = 1'b0;
    n = 0;
    while (!timeout_err && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("tmo_latency", 32'(n), 32'(TIMEOUT));
    check("tmo_req_busy", {30'd0, gyro_req, busy}, 32'd0);
    check("tmo_servo", {servo_roll, servo_pitch}, 32'h0100_0200);
`endif

    // Reset during REQ_PITCH clears everything at once and discards the frame.
    enable = 1'b1;
    wait_req("rstmid", n);
    drive_ack(16'h7FFF, 1);
    check("rstmid_in_pitch", 32'(gyro_axis), 32'd1);
    reset = 1'b1;
    #1;
    check("rstmid_servo", {servo_roll, servo_pitch}, 32'd0);
    check("rstmid_ctl", {29'd0, gyro_req, gyro_axis, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_req("post_rst", n);
    check("post_rst_lat", 32'(n), 32'(TICK_DIV));
    run_frame(16'h0011, 16'h0022, 1, 1);
    enable = 1'b0;
    repeat (3) @(negedge clk);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("tmo_count", 32'(tmo_cnt), 32'(EXP_TMO));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=running expected=done");
    $fatal(1);
  end

endmodule

// File: doc/gyro_axis_sequencer.md
GYRO_AXIS_SEQUENCER -- requirements
Module: gyro_axis_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 1000: clk cycles per sample frame; legal range 2..65535.
REQ-002 Parameter TIMEOUT, default 63: maximum cycles to wait for gyro_ack per axis; legal range 1..255.
REQ-003 Port clk, input, 1: clock; all logic on the rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port enable, input, 1: permits new frames to start.
REQ-006 Port gyro_req, output, 1: sample request to the shared gyro source.
REQ-007 Port gyro_axis, output, 1: axis being requested (0 = roll, 1 = pitch).
REQ-008 Port gyro_ack, input, 1: source acknowledge; gyro_data is valid in the same cycle.
REQ-009 Port gyro_data, input, 16: signed sample from the source.
REQ-010 Port servo_roll, output, 16: last published roll command.
REQ-011 Port servo_pitch, output, 16: last published pitch command.
REQ-012 Port update_valid, output, 1: one-cycle pulse when both servo outputs are updated.
REQ-013 Port busy, output, 1: high while a frame is in progress (state != IDLE).
REQ-014 Port overrun, output, 1: one-cycle pulse when a tick arrives while busy.
REQ-015 Port timeout_err, output, 1: one-cycle pulse when a request is aborted.

Function
REQ-016 The 16-bit tick counter SHALL count 0..TICK_DIV-1, wrap to 0, and assert an internal tick in the cycle it equals TICK_DIV-1; it runs regardless of enable.
REQ-017 The FSM SHALL have the states IDLE, REQ_ROLL and REQ_PITCH.
REQ-018 IDLE -> REQ_ROLL on a tick with enable=1; gyro_req=1 and gyro_axis=0 SHALL be visible in the next cycle.
REQ-019 In REQ_ROLL, gyro_ack=1 SHALL capture gyro_data into the roll shadow register and move to REQ_PITCH; gyro_req stays 1 and gyro_axis becomes 1 in the next cycle.
REQ-020 In REQ_PITCH, gyro_ack=1 SHALL load servo_roll from the roll shadow and servo_pitch from gyro_data at the same edge, pulse update_valid for the following cycle, and return to IDLE.
REQ-021 Both servo outputs SHALL change together, only on update_valid; there is no partial update.
REQ-022 gyro_req SHALL be 1 exactly in REQ_ROLL and REQ_PITCH; gyro_ack in IDLE SHALL be ignored.
REQ-023 A tick while busy SHALL be dropped and SHALL pulse overrun; the frame in progress continues unaffected.
REQ-024 Deasserting enable mid-frame SHALL NOT abort the frame; only the next start is blocked.
REQ-025 Data SHALL pass unmodified: no scaling, no saturation, no sign change.

Reset
REQ-026 While reset=1: state=IDLE, tick counter=0, roll shadow=0, servo_roll=0, servo_pitch=0, gyro_req=0, gyro_axis=0, update_valid=0, busy=0, overrun=0, timeout_err=0.
REQ-027 Reset asserted mid-frame SHALL take effect immediately (asynchronous assertion) and discard the frame; the first tick after release occurs TICK_DIV cycles later.

Configuration
REQ-028 Macro GYRO_SEQ_TIMEOUT_EN defined: an 8-bit wait counter clears on entry to each REQ state; if it reaches TIMEOUT without gyro_ack, the FSM returns to IDLE, gyro_req drops, timeout_err pulses for one cycle, and the servo outputs keep their previous values with no update_valid.
REQ-029 Macro GYRO_SEQ_TIMEOUT_EN undefined: there is no wait counter, the FSM waits indefinitely for gyro_ack, and timeout_err SHALL be tied to 0.

Verification
REQ-030 TICK_DIV=10, enable=1, ack 2 cycles after each req, data roll 0x1234, pitch 0xFEDC -> gyro_req rises 1 cycle after the tick; servo_roll=0x1234 and servo_pitch=0xFEDC with a single update_valid pulse.
REQ-031 enable=0 for 50 cycles with TICK_DIV=10 -> gyro_req never asserts; outputs stay 0.
REQ-032 TICK_DIV=4, ack withheld 6 cycles -> overrun pulses at each tick while busy; frame completes normally afterwards.
REQ-033 GYRO_SEQ_TIMEOUT_EN defined, TIMEOUT=5, roll never acked -> timeout_err pulse, gyro_req=0, servo outputs unchanged (prior 0x0100/0x0200 retained).
REQ-034 reset pulsed in REQ_PITCH after roll 0x7FFF captured -> all outputs 0 immediately; the next frame publishes fresh data only.
REQ-035 gyro_ack held high in IDLE for 20 cycles -> no capture, no update_valid.
